// File: rtl/round_timer_ctrl_pkg.sv
// round_timer_ctrl_pkg: shared state encodings, display width and helpers for the round timer
package round_timer_ctrl_pkg;
   localparam int DW = 4;
   localparam int DEF_CLK_PER_TICK = 50_000_000;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARM    = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   typedef struct packed {
      logic          round_start;
      logic          sample;
      logic          game_over;
      logic          active;
      logic [DW-1:0] time_left;
      logic [DW-1:0] round_num;
   } out_t;
   // only these states consume prescaler ticks and honour Hold
   function automatic logic is_timed(input logic [2:0] s);
      return s == S_RUN || s == S_GAP;
   endfunction
   function automatic logic is_active(input logic [2:0] s);
      return s == S_ARM || s == S_RUN || s == S_SAMPLE || s == S_GAP;
   endfunction
endpackage

// File: rtl/round_timer_ctrl_if.sv
// round_timer_ctrl_if: control inputs and display/handshake outputs of the round timer
interface round_timer_ctrl_if;
   import round_timer_ctrl_pkg::*;
   logic          Allow;
   logic          Go;
   logic          Hold;
   logic          RoundStart;
   logic          Sample;
   logic          GameOver;
   logic          Active;
   logic [DW-1:0] TimeLeft;
   logic [DW-1:0] RoundNum;
   modport master (output Allow, Go, Hold,
                   input  RoundStart, Sample, GameOver, Active, TimeLeft, RoundNum);
   modport slave  (input  Allow, Go, Hold,
                   output RoundStart, Sample, GameOver, Active, TimeLeft, RoundNum);
endinterface

// File: rtl/round_timer_ctrl_tick_prescaler.sv
// tick_prescaler: modulo-CLK_PER_TICK counter with a one-cycle Tick on wrap
module tick_prescaler #(
   parameter int CLK_PER_TICK = 4
) (
   input  logic Clk,
   input  logic Rst,
   input  logic En,
   input  logic Clr,
   output logic Tick
);
   localparam int W = $clog2(CLK_PER_TICK);
   logic [W-1:0] cnt_q, cnt_d;
   assign Tick = En && !Clr && cnt_q == W'(CLK_PER_TICK - 1);
   always_comb cnt_d = Clr ? '0 : !En ? cnt_q : Tick ? '0 : cnt_q + W'(1);
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: timed round sequencer issuing RoundStart/Sample per round and GameOver at the end
module round_timer_ctrl
   import round_timer_ctrl_pkg::*;
#(
   parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
   parameter int ROUND_TICKS  = 10,
   parameter int GAP_TICKS    = 2,
   parameter int MAX_ROUNDS   = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   round_timer_ctrl_if.slave   bus
);
   logic [2:0]    state_q, state_d;
   logic [DW-1:0] gap_q, gap_d;
   out_t          out_q, out_d;
   logic          tick, pre_en, pre_clr;
   // clearing on Allow low suppresses a coincident tick so an abort never yields a Sample
   assign pre_en  = is_timed(state_q) && !bus.Hold;
   assign pre_clr = !bus.Allow || !is_timed(state_q);
   tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_pre (
      .Clk  (Clk),
      .Rst  (Rst),
      .En   (pre_en),
      .Clr  (pre_clr),
      .Tick (tick)
   );
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE, S_DONE: if (bus.Go) begin
            state_d         = S_ARM;
            out_d.round_num = DW'(1);
         end
         S_ARM: state_d = S_RUN;
         S_RUN: if (tick) begin
            out_d.time_left = out_q.time_left - DW'(1);
            if (out_q.time_left == DW'(1)) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            state_d = (out_q.round_num == DW'(MAX_ROUNDS)) ? S_DONE : S_GAP;
            gap_d   = '0;
         end
         S_GAP: if (tick) begin
            gap_d = gap_q + DW'(1);
            if (gap_q == DW'(GAP_TICKS - 1)) begin
               state_d         = S_ARM;
               out_d.round_num = out_q.round_num + DW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!bus.Allow) state_d = S_IDLE;
      if (state_d == S_ARM) out_d.time_left = DW'(ROUND_TICKS);
      if (state_d == S_IDLE) begin
         out_d.time_left = '0;
         out_d.round_num = '0;
      end
      out_d.round_start = state_d == S_ARM;
      out_d.sample      = state_d == S_SAMPLE;
      out_d.game_over   = state_d == S_DONE;
      out_d.active      = is_active(state_d);
   end
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
      end
   assign bus.RoundStart = out_q.round_start;
   assign bus.Sample     = out_q.sample;
   assign bus.GameOver   = out_q.game_over;
   assign bus.Active     = out_q.active;
   assign bus.TimeLeft   = out_q.time_left;
   assign bus.RoundNum   = out_q.round_num;
endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb_round_timer_ctrl: vector table, corner-case sequences and a randomized reference-model run
module tb_round_timer_ctrl;
   localparam int C = 4, RT = 3, GT = 1, MR = 2;
   localparam int L = 2 + RT*C + GT*C;
   localparam int END_POS = (MR-1)*L + RT*C + 2;
   localparam int NV = 20;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int errors = 0, checks = 0;
   int m_mode = 0, m_pos = 0;
   round_timer_ctrl_if bus();
   round_timer_ctrl #(
      .CLK_PER_TICK (C),
      .ROUND_TICKS  (RT),
      .GAP_TICKS    (GT),
      .MAX_ROUNDS   (MR)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );
   always #5 Clk = ~Clk;
   typedef struct {
      int n;
      int a;
      int g;
      int h;
      logic [11:0] e;
   } vec_t;
   vec_t v[NV];
   function automatic logic [11:0] pk(input int rs, smp, gov, act, tl, rn);
      return {rs[0], smp[0], gov[0], act[0], tl[3:0], rn[3:0]};
   endfunction
   function automatic logic [11:0] dut_out();
      return {bus.RoundStart, bus.Sample, bus.GameOver, bus.Active, bus.TimeLeft, bus.RoundNum};
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask
   task automatic drive(input int a, input int g, input int h);
      bus.Allow = a[0];
      bus.Go    = g[0];
      bus.Hold  = h[0];
   endtask
   // game position model: a game is a fixed timeline of cycles that only stalls under Hold in RUN/GAP
   function automatic logic [11:0] model_out();
      int r, off, tl;
      if (m_mode == 0) return '0;
      if (m_mode == 2) return pk(0, 0, 1, 0, 0, MR);
      r   = m_pos / L + 1;
      off = m_pos % L;
      tl  = (off == 0) ? RT : (off <= RT*C) ? RT - (off-1)/C : 0;
      return pk(off == 0 ? 1 : 0, off == RT*C+1 ? 1 : 0, 0, 1, tl, r);
   endfunction
   task automatic model_step(input int a, input int g, input int h);
      int off;
      if (a == 0) m_mode = 0;
      else if (m_mode != 1) begin
         if (g != 0) begin
            m_mode = 1;
            m_pos  = 0;
         end
      end else begin
         off = m_pos % L;
         if (!(h != 0 && off != 0 && off != RT*C+1)) m_pos++;
         if (m_pos == END_POS) m_mode = 2;
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int cnt, seen;
      v[0]  = '{2, 0, 1, 0, pk(0,0,0,0,0,0)};
      v[1]  = '{1, 1, 1, 0, pk(1,0,0,1,3,1)};
      v[2]  = '{1, 1, 0, 0, pk(0,0,0,1,3,1)};
      v[3]  = '{3, 1, 0, 0, pk(0,0,0,1,3,1)};
      v[4]  = '{1, 1, 0, 0, pk(0,0,0,1,2,1)};
      v[5]  = '{4, 1, 0, 0, pk(0,0,0,1,1,1)};
      v[6]  = '{3, 1, 0, 0, pk(0,0,0,1,1,1)};
      v[7]  = '{1, 1, 0, 0, pk(0,1,0,1,0,1)};
      v[8]  = '{1, 1, 0, 1, pk(0,0,0,1,0,1)};
      v[9]  = '{3, 1, 1, 0, pk(0,0,0,1,0,1)};
      v[10] = '{1, 1, 0, 0, pk(1,0,0,1,3,2)};
      v[11] = '{1, 1, 0, 1, pk(0,0,0,1,3,2)};
      v[12] = '{1, 1, 1, 0, pk(0,0,0,1,3,2)};
      v[13] = '{10, 1, 0, 0, pk(0,0,0,1,1,2)};
      v[14] = '{1, 1, 0, 0, pk(0,1,0,1,0,2)};
      v[15] = '{1, 1, 0, 0, pk(0,0,1,0,0,2)};
      v[16] = '{5, 1, 0, 0, pk(0,0,1,0,0,2)};
      v[17] = '{1, 1, 1, 0, pk(1,0,0,1,3,1)};
      v[18] = '{1, 1, 0, 0, pk(0,0,0,1,3,1)};
      v[19] = '{1, 0, 0, 0, pk(0,0,0,0,0,0)};
      drive(0, 0, 0);
      step(2);
      chk("reset", 32'(dut_out()), 0);
      Rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         drive(v[i].a, v[i].g, v[i].h);
         step(v[i].n);
         chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(v[i].e));
      end
      drive(1, 1, 0);
      step(1);
      chk("hold_rs", 32'(bus.RoundStart), 1);
      drive(1, 0, 0);
      step(5);
      chk("hold_tl_before", 32'(bus.TimeLeft), 2);
      drive(1, 0, 1);
      step(10);
      chk("hold_tl_frozen", 32'(bus.TimeLeft), 2);
      drive(1, 0, 0);
      cnt = 15;
      while (!bus.Sample && cnt < 60) begin
         step(1);
         cnt++;
      end
      chk("hold_sample_delay", cnt, 23);
      drive(0, 0, 0);
      step(1);
      chk("hold_abort_idle", 32'(dut_out()), 0);
      drive(1, 1, 0);
      step(1);
      drive(1, 0, 0);
      step(12);
      chk("tick_tl", 32'(bus.TimeLeft), 1);
      drive(0, 0, 0);
      step(1);
      chk("tick_abort", 32'(dut_out()), 0);
      seen = 0;
      repeat (3) begin
         step(1);
         seen |= (bus.Sample || bus.Active) ? 1 : 0;
      end
      chk("tick_no_sample", seen, 0);
      drive(1, 1, 0);
      step(1);
      drive(1, 0, 0);
      step(14);
      chk("gap_active", 32'(dut_out()), 32'(pk(0,0,0,1,0,1)));
      #2 Rst = 1'b1;
      #1 chk("async_rst", 32'(dut_out()), 0);
      #2 Rst = 1'b0;
      step(1);
      chk("rst_idle", 32'(dut_out()), 0);
      drive(1, 1, 0);
      step(1);
      chk("rst_restart", 32'(dut_out()), 32'(pk(1,0,0,1,3,1)));
      drive(0, 0, 0);
      step(1);
      m_mode = 0;
      m_pos  = 0;
      for (int i = 0; i < 3000; i++) begin
         int a, g, h;
         a = ($urandom_range(63) != 0) ? 1 : 0;
         g = ($urandom_range(5) == 0) ? 1 : 0;
         h = ($urandom_range(4) == 0) ? 1 : 0;
         drive(a, g, h);
         model_step(a, g, h);
         step(1);
         chk($sformatf("rand%0d", i), 32'(dut_out()), 32'(model_out()));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
